// File: rtl/de_write_combiner.sv
// Write combiner between the draw engine and the frame store: merges byte-lane
// writes to one 32-bit word into a single masked write; reads flush then pass through.
module de_write_combiner #(
    parameter int IDLE_FLUSH = 8,
    parameter int AW         = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de_req,
    output logic          de_ack,
    input  logic [AW-1:0] de_addr,
    input  logic [3:0]    de_nbyte,
    input  logic          de_rnw,
    input  logic [31:0]   de_w_data,
    output logic [31:0]   de_r_data,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_nbyte,
    output logic          mem_rnw,
    output logic [31:0]   mem_w_data,
    input  logic [31:0]   mem_r_data,
    input  logic          flush,
    output logic          pending
);

    localparam int              CW       = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'((IDLE_FLUSH > 0) ? IDLE_FLUSH - 1 : 0);

    typedef enum logic [1:0] {EMPTY, HOLD, WB, RD} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]    buf_en_q, buf_en_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          de_ack_q, de_ack_d;
    logic [31:0]   de_r_data_q, de_r_data_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_rnw_q, mem_rnw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]    mem_nbyte_q, mem_nbyte_d;
    logic [31:0]   mem_w_data_q, mem_w_data_d;

    logic          sample;
    logic          addr_hit;
    logic          timeout;
    logic [3:0]    lane_wr;
    logic [31:0]   merged;

    // A request is only sampled while no ack is showing, so a held de_req
    // is never counted twice.
    assign sample   = de_req & ~de_ack_q;
    assign addr_hit = (de_addr == buf_addr_q);
    assign lane_wr  = ~de_nbyte;
    assign timeout  = (IDLE_FLUSH != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        merged = buf_data_q;
        for (int i = 0; i < 4; i++) begin
            if (lane_wr[i]) merged[8*i +: 8] = de_w_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_addr_d   = buf_addr_q;
        buf_en_d     = buf_en_q;
        buf_data_d   = buf_data_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        de_ack_d     = 1'b0;
        de_r_data_d  = de_r_data_q;
        mem_req_d    = mem_req_q;
        mem_rnw_d    = mem_rnw_q;
        mem_addr_d   = mem_addr_q;
        mem_nbyte_d  = mem_nbyte_q;
        mem_w_data_d = mem_w_data_q;

        case (state_q)
            EMPTY: begin
                if (sample) begin
                    if (de_rnw) begin
                        state_d     = RD;
                        mem_req_d   = 1'b1;
                        mem_rnw_d   = 1'b1;
                        mem_addr_d  = de_addr;
                        mem_nbyte_d = 4'b0000;
                    end else begin
                        de_ack_d = 1'b1;
                        if (de_nbyte != 4'b1111) begin
                            state_d      = HOLD;
                            buf_addr_d   = de_addr;
                            buf_en_d     = lane_wr;
                            buf_data_d   = merged;
                            cnt_d        = '0;
                            flush_pend_d = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                if (sample && !de_rnw && addr_hit) begin
                    // A flush arriving with a merge is remembered and honoured next edge.
                    buf_en_d     = buf_en_q | lane_wr;
                    buf_data_d   = merged;
                    de_ack_d     = 1'b1;
                    cnt_d        = '0;
                    flush_pend_d = flush;
                end else if (sample || (buf_en_q == 4'b1111) || flush || flush_pend_q || timeout) begin
                    state_d      = WB;
                    flush_pend_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_rnw_d    = 1'b0;
                    mem_addr_d   = buf_addr_q;
                    mem_nbyte_d  = ~buf_en_q;
                    mem_w_data_d = buf_data_q;
                end else if (IDLE_FLUSH != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                if (mem_ack) begin
                    state_d      = EMPTY;
                    mem_req_d    = 1'b0;
                    mem_nbyte_d  = 4'b0000;
                    mem_w_data_d = '0;
                    buf_en_d     = 4'b0000;
                    buf_data_d   = '0;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_d     = EMPTY;
                    mem_req_d   = 1'b0;
                    mem_rnw_d   = 1'b0;
                    de_r_data_d = mem_r_data;
                    de_ack_d    = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            buf_addr_q   <= '0;
            buf_en_q     <= 4'b0000;
            buf_data_q   <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            de_ack_q     <= 1'b0;
            de_r_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_rnw_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_nbyte_q  <= 4'b0000;
            mem_w_data_q <= '0;
        end else begin
            state_q      <= state_d;
            buf_addr_q   <= buf_addr_d;
            buf_en_q     <= buf_en_d;
            buf_data_q   <= buf_data_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            de_ack_q     <= de_ack_d;
            de_r_data_q  <= de_r_data_d;
            mem_req_q    <= mem_req_d;
            mem_rnw_q    <= mem_rnw_d;
            mem_addr_q   <= mem_addr_d;
            mem_nbyte_q  <= mem_nbyte_d;
            mem_w_data_q <= mem_w_data_d;
        end
    end

    assign de_ack     = de_ack_q;
    assign de_r_data  = de_r_data_q;
    assign mem_req    = mem_req_q;
    assign mem_rnw    = mem_rnw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_nbyte  = mem_nbyte_q;
    assign mem_w_data = mem_w_data_q;
    assign pending    = (state_q == HOLD) || (state_q == WB);

endmodule

// File: tb/tb_de_write_combiner.sv
// Bench for de_write_combiner: draw-engine driver, randomly delayed memory responder,
// and a scoreboard of expected memory transactions and read data.
`timescale 1ns/1ps
module tb_de_write_combiner;

    localparam int AW         = 18;
    localparam int IDLE_FLUSH = 8;
    localparam int TW         = 1 + AW + 4 + 32;

    logic          clk;
    logic          rst_n;
    logic          de_req;
    logic          de_ack;
    logic [AW-1:0] de_addr;
    logic [3:0]    de_nbyte;
    logic          de_rnw;
    logic [31:0]   de_w_data;
    logic [31:0]   de_r_data;
    logic          mem_req;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_nbyte;
    logic          mem_rnw;
    logic [31:0]   mem_w_data;
    logic [31:0]   mem_r_data;
    logic          flush;
    logic          pending;

    de_write_combiner #(.IDLE_FLUSH(IDLE_FLUSH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .de_req    (de_req),
        .de_ack    (de_ack),
        .de_addr   (de_addr),
        .de_nbyte  (de_nbyte),
        .de_rnw    (de_rnw),
        .de_w_data (de_w_data),
        .de_r_data (de_r_data),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_nbyte (mem_nbyte),
        .mem_rnw   (mem_rnw),
        .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data),
        .flush     (flush),
        .pending   (pending)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mem_txn_cnt = 0;
    logic [TW-1:0] exp_q[$];
    logic [31:0]   rd_q[$];
    logic          mem_hold = 1'b0;
    logic [31:0]   rd_value = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void exp_wr(input logic [AW-1:0] a, input logic [3:0] nb, input logic [31:0] d);
        exp_q.push_back({1'b0, a, nb, d});
    endfunction

    function automatic void exp_rd(input logic [AW-1:0] a);
        exp_q.push_back({1'b1, a, 4'b0000, 32'h0});
    endfunction

    // memory responder + scoreboard compare on each acknowledged transaction
    initial begin
        int wait_cnt;
        logic [TW-1:0] got;
        logic [TW-1:0] exp;
        wait_cnt = 0;
        mem_ack = 1'b0;
        mem_r_data = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !mem_hold) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    got = {mem_rnw, mem_addr, mem_nbyte, mem_rnw ? 32'h0 : mem_w_data};
                    check_eq("mem_exp_avail", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check_eq("mem_txn", 64'(got), 64'(exp));
                    end
                    mem_txn_cnt++;
                    mem_r_data = mem_rnw ? rd_value : $urandom();
                    mem_ack = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end
            end
        end
    end

    // driver tasks
    task automatic de_xfer(input logic [AW-1:0] a, input logic [3:0] nb, input logic rnw,
                           input logic [31:0] wd, output logic [31:0] rd, output int ack_cyc);
        bit got = 1'b0;
        de_req = 1'b1; de_addr = a; de_nbyte = nb; de_rnw = rnw; de_w_data = wd;
        rd = 32'h0;
        ack_cyc = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (de_ack) begin
                got = 1'b1;
                rd = de_r_data;
                ack_cyc = cyc;
            end
        end
        check_eq("de_ack_seen", 64'(got), 64'd1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [3:0] nb, input logic [31:0] wd);
        logic [31:0] r;
        int c;
        de_xfer(a, nb, 1'b0, wd, r, c);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (pending || mem_req); i++) @(negedge clk);
        check_eq("idle_reached", 64'(pending || mem_req), 64'd0);
    endtask

    initial begin
        int ack_c[4];
        int c;
        int lat;
        int n0;
        logic [31:0] r;
        logic [31:0] rexp;
        logic [3:0]  m_en;
        logic [31:0] m_data;
        logic [AW-1:0] ra;
        logic [3:0]  nb;
        logic [31:0] wd;

        rst_n = 1'b0; de_req = 1'b0; de_addr = '0; de_nbyte = 4'b1111;
        de_rnw = 1'b0; de_w_data = 32'h0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_de_ack", 64'(de_ack), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_rnw", 64'(mem_rnw), 64'd0);
        check_eq("rst_mem_nbyte", 64'(mem_nbyte), 64'd0);
        check_eq("rst_de_r_data", 64'(de_r_data), 64'd0);
        check_eq("rst_pending", 64'(pending), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // four lane writes to one word, de_req held throughout
        exp_wr(18'h00100, 4'b0000, 32'h44332211);
        n0 = mem_txn_cnt;
        de_xfer(18'h00100, 4'b1110, 1'b0, {4{8'h11}}, r, ack_c[0]);
        de_xfer(18'h00100, 4'b1101, 1'b0, {4{8'h22}}, r, ack_c[1]);
        de_xfer(18'h00100, 4'b1011, 1'b0, {4{8'h33}}, r, ack_c[2]);
        de_xfer(18'h00100, 4'b0111, 1'b0, {4{8'h44}}, r, ack_c[3]);
        de_req = 1'b0;
        for (int i = 1; i < 4; i++) check_eq("burst_ack_gap", 64'(ack_c[i] - ack_c[i-1]), 64'd2);
        wait_idle();
        check_eq("burst_one_write", 64'(mem_txn_cnt - n0), 64'd1);

        // address change forces write-back before the new write is acked
        exp_wr(18'h00005, 4'b1110, 32'h000000AA);
        exp_wr(18'h00006, 4'b1011, 32'h00CC0000);
        wr(18'h00005, 4'b1110, 32'hDEADBEAA);
        n0 = mem_txn_cnt;
        wr(18'h00006, 4'b1011, 32'h55CC5555);
        de_req = 1'b0;
        check_eq("miss_flush_before_ack", 64'(mem_txn_cnt - n0), 64'd1);
        wait_idle();

        // idle timeout
        exp_wr(18'h00300, 4'b1110, 32'h00000077);
        wr(18'h00300, 4'b1110, 32'h12345677);
        de_req = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !mem_req; i++) begin
            @(negedge clk);
            lat++;
        end
        check_eq("idle_flush_latency", 64'(lat), 64'(IDLE_FLUSH));
        check_eq("pending_in_wb", 64'(pending), 64'd1);
        for (int i = 0; i < 20 && mem_req; i++) @(negedge clk);
        check_eq("pending_after_ack", 64'(pending), 64'd0);

        // read to a buffered address: write-back first, then read
        exp_wr(18'h00020, 4'b1101, 32'h00005A00);
        exp_rd(18'h00020);
        rd_value = 32'hDEADBEEF;
        rd_q.push_back(32'hDEADBEEF);
        wr(18'h00020, 4'b1101, 32'hFFFF5AFF);
        de_xfer(18'h00020, 4'b1111, 1'b1, 32'h0, r, c);
        de_req = 1'b0;
        check_eq("rd_q_avail", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
            rexp = rd_q.pop_front();
            check_eq("read_data", 64'(r), 64'(rexp));
        end
        wait_idle();

        // all-lanes-disabled write is acked and dropped
        n0 = mem_txn_cnt;
        wr(18'h00500, 4'b1111, 32'hFFFFFFFF);
        de_req = 1'b0;
        check_eq("nop_pending", 64'(pending), 64'd0);
        repeat (12) @(negedge clk);
        check_eq("nop_no_mem", 64'(mem_txn_cnt - n0), 64'd0);

        // reset while a write-back is outstanding
        mem_hold = 1'b1;
        wr(18'h00400, 4'b0111, 32'h99000000);
        de_req = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check_eq("wb_entered", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("async_rst_de_ack", 64'(de_ack), 64'd0);
        check_eq("async_rst_pending", 64'(pending), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        exp_wr(18'h00401, 4'b1110, 32'h00000012);
        wr(18'h00401, 4'b1110, 32'hABCDEF12);
        de_req = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle();

        // flush coinciding with a matching write
        exp_wr(18'h00040, 4'b1010, 32'h00330011);
        wr(18'h00040, 4'b1110, {4{8'h11}});
        de_addr = 18'h00040; de_nbyte = 4'b1011; de_w_data = {4{8'h33}};
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_merge_ack", 64'(de_ack), 64'd1);
        check_eq("flush_merge_first", 64'(mem_req), 64'd0);
        flush = 1'b0;
        de_req = 1'b0;
        @(negedge clk);
        check_eq("flush_merge_wb_next", 64'(mem_req), 64'd1);
        wait_idle();

        // random merge rounds against a lane-merge model
        for (int rnd = 0; rnd < 3; rnd++) begin
            ra = 18'($urandom_range(0, 262143));
            m_en = 4'b0000;
            m_data = 32'h0;
            for (int k = 0; k < 6; k++) begin
                nb = 4'($urandom_range(0, 14));
                wd = $urandom();
                for (int l = 0; l < 4; l++) begin
                    if (!nb[l]) begin
                        m_en[l] = 1'b1;
                        m_data[8*l +: 8] = wd[8*l +: 8];
                    end
                end
                if (m_en == 4'b1111) begin
                    exp_wr(ra, 4'b0000, m_data);
                    m_en = 4'b0000;
                    m_data = 32'h0;
                end
                wr(ra, nb, wd);
            end
            de_req = 1'b0;
            if (m_en != 4'b0000) exp_wr(ra, ~m_en, m_data);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check_eq("rd_q_drained", 64'(rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
